// File: rtl/modulate_quarter_rate_if.sv
// Stream bundle for the quarter-rate modulator: input sample stream and
// rotated output stream, both valid/ready.
interface modulate_quarter_rate_if #(
  parameter int G_DWIDTH = 24,
  parameter int G_CHW    = 1
);
  logic signed [G_DWIDTH-1:0] din_re;
  logic signed [G_DWIDTH-1:0] din_im;
  logic                       din_valid;
  logic                       din_ready;
  logic signed [G_DWIDTH-1:0] dout_re;
  logic signed [G_DWIDTH-1:0] dout_im;
  logic [G_CHW-1:0]           dout_ch;
  logic                       dout_valid;
  logic                       dout_ready;

  modport master (
    output din_re, din_im, din_valid,
    input  din_ready,
    input  dout_re, dout_im, dout_ch, dout_valid,
    output dout_ready
  );

  modport slave (
    input  din_re, din_im, din_valid,
    output din_ready,
    output dout_re, dout_im, dout_ch, dout_valid,
    input  dout_ready
  );
endinterface

// File: rtl/modulate_quarter_rate.sv
// Multiplies an interleaved complex stream by (-j)^n or (+j)^n, one phase
// step per frame of G_NUM_CH samples, with a single output register stage.
module modulate_quarter_rate #(
  parameter int G_DWIDTH   = 24,
  parameter int G_NUM_CH   = 1,
  parameter int G_SATURATE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic dir,
  input  logic phase_clear,
  modulate_quarter_rate_if.slave bus
);

  localparam int CHW = (G_NUM_CH > 1) ? $clog2(G_NUM_CH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(G_NUM_CH - 1);
  localparam logic signed [G_DWIDTH-1:0] MIN_VAL = {1'b1, {(G_DWIDTH-1){1'b0}}};
  localparam logic signed [G_DWIDTH-1:0] MAX_VAL = {1'b0, {(G_DWIDTH-1){1'b1}}};

  logic                       en_q;
  logic [1:0]                 phase;
  logic [CHW-1:0]             ch_cnt;
  logic                       accept;
  logic                       consume;
  logic                       frame_end;
  logic signed [G_DWIDTH-1:0] rot_re;
  logic signed [G_DWIDTH-1:0] rot_im;

  // Negating the most-negative code either clamps to the most-positive code
  // or wraps back onto itself, depending on G_SATURATE.
  function automatic logic signed [G_DWIDTH-1:0] negate(
    input logic signed [G_DWIDTH-1:0] x
  );
    if ((G_SATURATE != 0) && (x == MIN_VAL)) return MAX_VAL;
    return -x;
  endfunction

  assign bus.din_ready = en_q & (~bus.dout_valid | bus.dout_ready);
  assign accept        = bus.din_valid & bus.din_ready;
  assign consume       = bus.dout_valid & bus.dout_ready;
  assign frame_end     = (ch_cnt == LAST_CH);

  // Rotate the incoming sample by the current quarter-turn phase.
  always_comb begin
    rot_re = bus.din_re;
    rot_im = bus.din_im;
    case (phase)
      2'd0: begin
        rot_re = bus.din_re;
        rot_im = bus.din_im;
      end
      2'd1: begin
        rot_re = bus.din_im;
        rot_im = negate(bus.din_re);
      end
      2'd2: begin
        rot_re = negate(bus.din_re);
        rot_im = negate(bus.din_im);
      end
      default: begin
        rot_re = negate(bus.din_im);
        rot_im = bus.din_re;
      end
    endcase
  end

  // Enable pipeline: ready follows enable one cycle late.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) en_q <= 1'b0;
    else       en_q <= enable;
  end

  // Phase and channel counters; the phase steps once per completed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase  <= 2'd0;
      ch_cnt <= '0;
    end else if (!enable || phase_clear) begin
      phase  <= 2'd0;
      ch_cnt <= '0;
    end else if (accept) begin
      if (frame_end) begin
        ch_cnt <= '0;
        phase  <= dir ? (phase - 2'd1) : (phase + 2'd1);
      end else begin
        ch_cnt <= ch_cnt + 1'b1;
      end
    end
  end

  // Output register: load on accept, empty on consume, flush when disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.dout_valid <= 1'b0;
      bus.dout_re    <= '0;
      bus.dout_im    <= '0;
      bus.dout_ch    <= '0;
    end else if (!enable) begin
      bus.dout_valid <= 1'b0;
    end else if (accept) begin
      bus.dout_valid <= 1'b1;
      bus.dout_re    <= rot_re;
      bus.dout_im    <= rot_im;
      bus.dout_ch    <= ch_cnt;
    end else if (consume) begin
      bus.dout_valid <= 1'b0;
    end
  end

endmodule
